vga_timing_gen: RTL and testbench

//  Upstream timing stage of the character generator. Divides the system clock into a pixel-enable

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing for the character generator: pixel-enable divider, h/v counters,
// and sync/blank outputs delayed to line up with the pixel memory path.
module vga_timing_gen #(
    parameter int unsigned PIX_DIV         = 4,
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter int unsigned SYNC_DELAY      = 2,
    parameter int unsigned VGA_MAX_H_WIDTH = 10,
    parameter int unsigned VGA_MAX_V_WIDTH = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       pix_en_o,
    output logic [VGA_MAX_H_WIDTH-1:0] hcount_o,
    output logic [VGA_MAX_V_WIDTH-1:0] vcount_o,
    output logic                       visible_o,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       blank_o,
    output logic                       frame_start_o
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned DIV_W        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0]           DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [VGA_MAX_H_WIDTH-1:0] H_LAST   = VGA_MAX_H_WIDTH'(H_TOTAL - 1);
    localparam logic [VGA_MAX_V_WIDTH-1:0] V_LAST   = VGA_MAX_V_WIDTH'(V_TOTAL - 1);

    if (PIX_DIV < 1) begin : g_div_chk
        $error("PIX_DIV must be at least 1");
    end
    if (longint'(H_TOTAL) > (longint'(1) << VGA_MAX_H_WIDTH)) begin : g_h_width_chk
        $error("H_TOTAL-1 does not fit VGA_MAX_H_WIDTH");
    end
    if (longint'(V_TOTAL) > (longint'(1) << VGA_MAX_V_WIDTH)) begin : g_v_width_chk
        $error("V_TOTAL-1 does not fit VGA_MAX_V_WIDTH");
    end

    logic [DIV_W-1:0]           div_cnt_q;
    logic [VGA_MAX_H_WIDTH-1:0] hcount_q, hcount_d;
    logic [VGA_MAX_V_WIDTH-1:0] vcount_q, vcount_d;
    logic                       pix_en;
    logic                       raw_hsync, raw_vsync, raw_blank;

    assign pix_en = (div_cnt_q == DIV_LAST) && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    always_comb begin
        raw_hsync = !((32'(hcount_q) >= H_SYNC_START) && (32'(hcount_q) < H_SYNC_END));
        raw_vsync = !((32'(vcount_q) >= V_SYNC_START) && (32'(vcount_q) < V_SYNC_END));
        visible_o = (32'(hcount_q) < H_VISIBLE) && (32'(vcount_q) < V_VISIBLE);
        raw_blank = !visible_o;
    end

    // Stages hold {hsync, vsync, blank}; all-ones is the inactive (black, no sync) pattern.
    if (SYNC_DELAY == 0) begin : g_no_delay
        assign hsync_o = raw_hsync;
        assign vsync_o = raw_vsync;
        assign blank_o = raw_blank;
    end else begin : g_delay
        logic [2:0] dly_q [SYNC_DELAY];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                    dly_q[i] <= 3'b111;
                end
            end else if (pix_en) begin
                dly_q[0] <= {raw_hsync, raw_vsync, raw_blank};
                for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign hsync_o = dly_q[SYNC_DELAY-1][2];
        assign vsync_o = dly_q[SYNC_DELAY-1][1];
        assign blank_o = dly_q[SYNC_DELAY-1][0];
    end

    assign pix_en_o      = pix_en;
    assign hcount_o      = hcount_q;
    assign vcount_o      = vcount_q;
    assign frame_start_o = pix_en && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an
// arithmetic raster model, plus directed literal checks on key timing points.
module tb_vga_timing_gen;

    typedef struct packed {
        int pdiv; int dly;
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
    } geom_t;

    typedef struct {
        bit pix_en; int h; int v; bit vis; bit hsync; bit vsync; bit blank; bit fs;
    } exp_t;

    localparam geom_t GA = '{4, 2, 640, 16, 96, 48, 480, 10, 2, 33};
    localparam geom_t GB = '{1, 0, 640, 16, 96, 48, 480, 10, 2, 33};
    localparam geom_t GC = '{2, 3, 8, 2, 3, 2, 4, 1, 2, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_pe, a_vis, a_hs, a_vs, a_bl, a_fs;
    logic [9:0] a_h, a_v;
    logic       b_pe, b_vis, b_hs, b_vs, b_bl, b_fs;
    logic [9:0] b_h, b_v;
    logic       c_pe, c_vis, c_hs, c_vs, c_bl, c_fs;
    logic [9:0] c_h, c_v;

    vga_timing_gen u_a (
        .clk_i(clk), .rst_i(rst), .pix_en_o(a_pe), .hcount_o(a_h), .vcount_o(a_v),
        .visible_o(a_vis), .hsync_o(a_hs), .vsync_o(a_vs), .blank_o(a_bl), .frame_start_o(a_fs)
    );

    vga_timing_gen #(.PIX_DIV(1), .SYNC_DELAY(0)) u_b (
        .clk_i(clk), .rst_i(rst), .pix_en_o(b_pe), .hcount_o(b_h), .vcount_o(b_v),
        .visible_o(b_vis), .hsync_o(b_hs), .vsync_o(b_vs), .blank_o(b_bl), .frame_start_o(b_fs)
    );

    vga_timing_gen #(
        .PIX_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(3)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .pix_en_o(c_pe), .hcount_o(c_h), .vcount_o(c_v),
        .visible_o(c_vis), .hsync_o(c_hs), .vsync_o(c_vs), .blank_o(c_bl), .frame_start_o(c_fs)
    );

    int     n_total = 0;
    int     n_pass  = 0;
    bit     started = 1'b0;
    longint c_since = 0;

    // Clock edges since the last edge that saw reset.
    always @(posedge clk) c_since <= rst ? 0 : c_since + 1;

    task automatic chk(input string tag, input string name, input longint act,
                       input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s.%s: got %0d, expected %0d", tag, name, act, exp);
    endtask

    // Pixel n = c/pdiv since reset; delayed outputs show pixel n-dly, inactive before that.
    function automatic exp_t model(input geom_t g, input longint c, input bit r);
        exp_t   e;
        longint ht, vt, n, m, mh, mv;
        ht = g.hv + g.hf + g.hs + g.hb;
        vt = g.vv + g.vf + g.vs + g.vb;
        n  = c / g.pdiv;
        e.pix_en = !r && (c % g.pdiv == g.pdiv - 1);
        e.h   = int'(n % ht);
        e.v   = int'((n / ht) % vt);
        e.vis = (e.h < g.hv) && (e.v < g.vv);
        e.fs  = e.pix_en && e.h == 0 && e.v == 0;
        if (n >= g.dly) begin
            m  = n - g.dly;
            mh = m % ht;
            mv = (m / ht) % vt;
            e.hsync = !(mh >= g.hv + g.hf && mh < g.hv + g.hf + g.hs);
            e.vsync = !(mv >= g.vv + g.vf && mv < g.vv + g.vf + g.vs);
            e.blank = !(mh < g.hv && mv < g.vv);
        end else begin
            e.hsync = 1'b1;
            e.vsync = 1'b1;
            e.blank = 1'b1;
        end
        return e;
    endfunction

    task automatic check_inst(input string tag, input exp_t e, input logic pe,
                              input logic [9:0] h, input logic [9:0] v, input logic vis,
                              input logic hs, input logic vs, input logic bl, input logic fs);
        chk(tag, "pix_en", pe, e.pix_en);
        chk(tag, "hcount", h, e.h);
        chk(tag, "vcount", v, e.v);
        chk(tag, "visible", vis, e.vis);
        chk(tag, "hsync", hs, e.hsync);
        chk(tag, "vsync", vs, e.vsync);
        chk(tag, "blank", bl, e.blank);
        chk(tag, "frame_start", fs, e.fs);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_inst("a", model(GA, c_since, rst), a_pe, a_h, a_v, a_vis, a_hs, a_vs, a_bl, a_fs);
            check_inst("b", model(GB, c_since, rst), b_pe, b_h, b_v, b_vis, b_hs, b_vs, b_bl, b_fs);
            check_inst("c", model(GC, c_since, rst), c_pe, c_h, c_v, c_vis, c_hs, c_vs, c_bl, c_fs);
        end
    end

    initial begin
        int a_first = -1, a_last = -1, a_low = 0, a_bfirst = -1, a_bcnt = 0;
        int b_first = -1, b_last = -1, b_low = 0;
        int c_fcnt = 0, c_vlow = 0;
        bit found;

        @(posedge clk);
        #1 started = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst", "pix_en", a_pe, 0);
        chk("rst", "hcount", a_h, 0);
        chk("rst", "vcount", a_v, 0);
        chk("rst", "hsync", a_hs, 1);
        chk("rst", "vsync", a_vs, 1);
        chk("rst", "blank", a_bl, 1);
        chk("rst", "frame_start", a_fs, 0);
        chk("rst", "b_pix_en", b_pe, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Sample k is taken k clock edges after reset release.
        for (int k = 0; k < 3400; k++) begin
            @(negedge clk);
            if (k < 8) begin
                chk("rel", $sformatf("pix_en@%0d", k), a_pe, (k == 3 || k == 7) ? 1 : 0);
                chk("rel", $sformatf("hcount@%0d", k), a_h, (k < 4) ? 0 : 1);
            end
            if (a_v == 0 && !a_hs) begin
                if (a_first < 0) a_first = int'(a_h);
                a_last = int'(a_h);
                a_low++;
            end
            if (a_v == 0 && !a_bl) begin
                if (a_bfirst < 0) a_bfirst = int'(a_h);
                a_bcnt++;
            end
            if (b_v == 0 && !b_hs) begin
                if (b_first < 0) b_first = int'(b_h);
                b_last = int'(b_h);
                b_low++;
            end
            if (k < 2400) begin
                if (c_fs) c_fcnt++;
                if (!c_vs) c_vlow++;
            end
        end
        chk("line", "a_hsync_first_h", a_first, 658);
        chk("line", "a_hsync_last_h", a_last, 753);
        chk("line", "a_hsync_low_clks", a_low, 384);
        chk("line", "a_blank_first_h", a_bfirst, 2);
        chk("line", "a_blank_low_clks", a_bcnt, 2560);
        chk("line", "b_hsync_first_h", b_first, 656);
        chk("line", "b_hsync_last_h", b_last, 751);
        chk("line", "b_hsync_low_clks", b_low, 96);
        chk("frame", "c_frame_starts", c_fcnt, 10);
        chk("frame", "c_vsync_low_clks", c_vlow, 600);

        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (c_h == 14 && c_v == 7 && c_pe) found = 1'b1;
        end
        chk("cwrap", "reached", found, 1);
        @(negedge clk);
        chk("cwrap", "hcount", c_h, 0);
        chk("cwrap", "vcount", c_v, 0);
        chk("cwrap", "fs_early", c_fs, 0);
        @(negedge clk);
        chk("cwrap", "fs", c_fs, 1);

        found = 1'b0;
        for (int k = 0; k < 40000 && !found; k++) begin
            @(negedge clk);
            if (a_h == 799 && a_v == 10 && a_pe) found = 1'b1;
        end
        chk("awrap", "reached", found, 1);
        @(negedge clk);
        chk("awrap", "hcount", a_h, 0);
        chk("awrap", "vcount", a_v, 11);

        // Reset for one edge mid-line with the divider at phase 2.
        repeat (100) @(posedge clk);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(posedge clk);
            #1;
            if (c_since % 4 == 2) found = 1'b1;
        end
        chk("midrst", "aligned", found, 1);
        chk("midrst", "pre_vcount", a_v, 11);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst", "hcount", a_h, 0);
        chk("midrst", "vcount", a_v, 0);
        chk("midrst", "hsync", a_hs, 1);
        chk("midrst", "vsync", a_vs, 1);
        chk("midrst", "blank", a_bl, 1);
        chk("midrst", "pix_en", a_pe, 0);
        chk("midrst", "c_hcount", c_h, 0);

        repeat (500) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
